// File: rtl/inst_sequencer.sv
// Instruction sequencer: owns the instruction register and cycle counter, overlaps
// opcode fetch with cycle-0 writeback, and latches/acknowledges reset, NMI and IRQ.
module inst_sequencer #(
    parameter logic [7:0] INT_OP      = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic [7:0] databus,
    input  logic       icyc,
    input  logic       rcyc,
    input  logic       scyc,
    input  logic       sinst,
    input  logic       irqdis,
    input  logic       nmi_n,
    input  logic       irq_n,
    output logic [7:0] inst,
    output logic [2:0] cycle,
    output logic       clr,
    output logic       nmi,
    output logic       irq,
    output logic       sync,
    output logic       seq_err
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [0:0] {
        ST_EXEC  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [7:0]  inst_r, inst_nxt_s;
    logic [2:0]  cycle_r, cycle_nxt_s;
    logic        clr_r, clr_nxt_s;
    logic        nmi_r, nmi_nxt_s;
    logic        err_r, err_nxt_s;
    logic [SS-1:0] nmi_sync_r;
    logic [SS-1:0] irq_sync_r;
    logic        nmi_prev_r;
    logic        nmi_fall_s;
    logic        nmi_ack_s;
    logic        multi_err_s;
    logic        strobe_err_s;
    logic        ack_err_s;
    logic [3:0]  cycle_sum_s;
    logic [3:0]  cycle_inc_s;

    // Pin synchronizers and NMI edge history; they run regardless of rdy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_sync_r <= {SS{1'b1}};
            irq_sync_r <= {SS{1'b1}};
            nmi_prev_r <= 1'b1;
        end else begin
            nmi_sync_r <= {nmi_sync_r[SS-2:0], nmi_n};
            irq_sync_r <= {irq_sync_r[SS-2:0], irq_n};
            nmi_prev_r <= nmi_sync_r[SS-1];
        end
    end

    assign nmi_fall_s = nmi_prev_r & ~nmi_sync_r[SS-1];
    assign irq        = ~irq_sync_r[SS-1] & ~irqdis;

    // Next-state: strobe priority rcyc > scyc > icyc, request acknowledge, error detection
    always_comb begin
        state_nxt_s  = state_r;
        inst_nxt_s   = inst_r;
        cycle_nxt_s  = cycle_r;
        clr_nxt_s    = clr_r;
        nmi_ack_s    = 1'b0;
        strobe_err_s = 1'b0;
        ack_err_s    = 1'b0;
        multi_err_s  = (rcyc & scyc) | (rcyc & icyc) | (scyc & icyc);
        cycle_sum_s  = {1'b0, cycle_r} + 4'd2;
        cycle_inc_s  = {1'b0, cycle_r} + 4'd1;
        if (rdy) begin
            casez ({rcyc, scyc, icyc})
                3'b1??: begin
                    cycle_nxt_s = 3'd0;
                    state_nxt_s = ST_FETCH;
                end
                3'b01?: begin
                    if (state_r == ST_FETCH) begin
                        strobe_err_s = 1'b1;
                    end else begin
                        cycle_nxt_s  = cycle_sum_s[2:0];
                        strobe_err_s = cycle_sum_s[3];
                    end
                end
                3'b001: begin
                    if (state_r == ST_FETCH) begin
                        state_nxt_s = ST_EXEC;
                        // A pending request discards the fetched opcode
                        if (clr_r | nmi_r | irq) begin
                            inst_nxt_s  = INT_OP;
                            cycle_nxt_s = 3'd0;
                        end else begin
                            inst_nxt_s  = databus;
                            cycle_nxt_s = 3'd1;
                        end
                    end else begin
                        cycle_nxt_s  = cycle_inc_s[2:0];
                        strobe_err_s = cycle_inc_s[3];
                    end
                end
                default: begin
                    cycle_nxt_s = cycle_r;
                end
            endcase
            if (sinst) begin
                if (clr_r) begin
                    clr_nxt_s = 1'b0;
                end else if (nmi_r) begin
                    nmi_ack_s = 1'b1;
                end else if (!irq) begin
                    ack_err_s = 1'b1;
                end else begin
                    ack_err_s = 1'b0;
                end
            end else begin
                nmi_ack_s = 1'b0;
            end
        end else begin
            multi_err_s = 1'b0;
        end
        nmi_nxt_s = nmi_fall_s | (nmi_r & ~nmi_ack_s);
        err_nxt_s = err_r | multi_err_s | strobe_err_s | ack_err_s;
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EXEC;
            inst_r  <= INT_OP;
            cycle_r <= 3'd0;
            clr_r   <= 1'b1;
            nmi_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            inst_r  <= inst_nxt_s;
            cycle_r <= cycle_nxt_s;
            clr_r   <= clr_nxt_s;
            nmi_r   <= nmi_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign inst    = inst_r;
    assign cycle   = cycle_r;
    assign clr     = clr_r;
    assign nmi     = nmi_r;
    assign sync    = (state_r == ST_FETCH);
    assign seq_err = err_r;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_inst_sequencer;

    localparam int         S      = 2;
    localparam logic [7:0] INT_OP = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b1;
    logic [7:0] databus = 8'h00;
    logic       icyc = 1'b0, rcyc = 1'b0, scyc = 1'b0, sinst = 1'b0;
    logic       irqdis = 1'b0, nmi_n = 1'b1, irq_n = 1'b1;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       clr, nmi, irq, sync, seq_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_inst;
    int         m_cycle;
    bit         m_fetch, m_clr, m_nmi, m_err;
    bit         nmi_hist[$];
    bit         irq_hist[$];

    inst_sequencer #(.INT_OP(INT_OP), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .databus(databus),
        .icyc(icyc), .rcyc(rcyc), .scyc(scyc), .sinst(sinst),
        .irqdis(irqdis), .nmi_n(nmi_n), .irq_n(irq_n),
        .inst(inst), .cycle(cycle), .clr(clr), .nmi(nmi), .irq(irq),
        .sync(sync), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_inst = INT_OP; m_cycle = 0; m_fetch = 1'b0;
        m_clr = 1'b1; m_nmi = 1'b0; m_err = 1'b0;
        nmi_hist.delete();
        irq_hist.delete();
        for (int i = 0; i <= S; i++) begin
            nmi_hist.push_back(1'b1);
            irq_hist.push_back(1'b1);
        end
    endtask

    function automatic bit m_irq();
        return !irq_hist[S-1] && !irqdis;
    endfunction

    // One rising edge of the model; pins are seen S edges late, nmi one more for edge detect
    task automatic model_update();
        bit irq_cur, nmi_fall, ack;
        int n;
        irq_cur  = m_irq();
        nmi_fall = nmi_hist[S] && !nmi_hist[S-1];
        ack = 1'b0;
        if (rdy) begin
            n = int'(rcyc) + int'(scyc) + int'(icyc);
            if (n > 1) m_err = 1'b1;
            if (rcyc) begin
                m_cycle = 0; m_fetch = 1'b1;
            end else if (scyc) begin
                if (m_fetch) m_err = 1'b1;
                else begin
                    if (m_cycle + 2 > 7) m_err = 1'b1;
                    m_cycle = (m_cycle + 2) % 8;
                end
            end else if (icyc) begin
                if (m_fetch) begin
                    m_fetch = 1'b0;
                    if (m_clr || m_nmi || irq_cur) begin
                        m_inst = INT_OP; m_cycle = 0;
                    end else begin
                        m_inst = databus; m_cycle = 1;
                    end
                end else begin
                    if (m_cycle == 7) m_err = 1'b1;
                    m_cycle = (m_cycle + 1) % 8;
                end
            end
            if (sinst) begin
                if (m_clr) m_clr = 1'b0;
                else if (m_nmi) ack = 1'b1;
                else if (!irq_cur) m_err = 1'b1;
            end
        end
        m_nmi = nmi_fall || (m_nmi && !ack);
        nmi_hist.push_front(nmi_n); void'(nmi_hist.pop_back());
        irq_hist.push_front(irq_n); void'(irq_hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1'b1; icyc = 1'b0; rcyc = 1'b0; scyc = 1'b0; sinst = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({inst, cycle, clr, nmi, sync, seq_err} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got inst=%h cyc=%0d clr=%b nmi=%b sync=%b err=%b, want 00 0 1 0 0 0",
                     inst, cycle, clr, nmi, sync, seq_err);
        end
        icyc = 1'b1; sinst = 1'b1; tick(); idle();
        checks++;
        if ({clr, cycle, seq_err} !== {1'b0, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset_ack: got clr=%b cyc=%0d err=%b, want 0 1 0", clr, cycle, seq_err);
        end
    endtask

    task automatic test_nop_flow();
        rcyc = 1'b1; tick(); idle();
        databus = 8'hEA; icyc = 1'b1; tick(); idle();
        checks++;
        if ({inst, cycle} !== {8'hEA, 3'd1}) begin
            errors++;
            $display("FAIL nop_load: got inst=%h cyc=%0d, want ea 1", inst, cycle);
        end
        rcyc = 1'b1; tick(); idle();
        checks++;
        if ({inst, cycle, sync} !== {8'hEA, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL nop_rcyc: got inst=%h cyc=%0d sync=%b, want ea 0 1", inst, cycle, sync);
        end
        databus = 8'hA9; icyc = 1'b1; tick(); idle();
        checks++;
        if ({inst, cycle, sync} !== {8'hA9, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL lda_load: got inst=%h cyc=%0d sync=%b, want a9 1 0", inst, cycle, sync);
        end
    endtask

    task automatic test_irq_mask();
        irq_n = 1'b0; irqdis = 1'b1;
        for (int i = 0; i < S; i++) tick();
        rcyc = 1'b1; tick(); idle();
        databus = 8'h69; icyc = 1'b1; tick(); idle();
        checks++;
        if ({inst, irq} !== {8'h69, 1'b0}) begin
            errors++;
            $display("FAIL irq_masked: got inst=%h irq=%b, want 69 0", inst, irq);
        end
        irqdis = 1'b0;
        rcyc = 1'b1; tick(); idle();
        databus = 8'h69; icyc = 1'b1; tick(); idle();
        checks++;
        if ({inst, cycle, irq} !== {8'h00, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL irq_taken: got inst=%h cyc=%0d irq=%b, want 00 0 1", inst, cycle, irq);
        end
        irq_n = 1'b1;
        for (int i = 0; i < S + 1; i++) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_release: got irq=%b, want 0", irq);
        end
    endtask

    task automatic test_nmi();
        nmi_n = 1'b0;
        for (int i = 1; i <= S + 1; i++) begin
            tick();
            checks++;
            if (nmi !== (i == S + 1)) begin
                errors++;
                $display("FAIL nmi_latency: cycle %0d got nmi=%b, want %b", i, nmi, (i == S + 1));
            end
        end
        sinst = 1'b1; tick(); idle();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({nmi, clr, seq_err} !== {1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nmi_ack: got nmi=%b clr=%b err=%b, want 0 0 0", nmi, clr, seq_err);
        end
        nmi_n = 1'b1;
        for (int i = 0; i < S + 1; i++) tick();
    endtask

    task automatic test_errors();
        apply_reset();
        sinst = 1'b1; tick(); idle();
        for (int i = 0; i < 7; i++) begin
            icyc = 1'b1; tick(); idle();
        end
        checks++;
        if ({cycle, seq_err} !== {3'd7, 1'b0}) begin
            errors++;
            $display("FAIL cyc7: got cyc=%0d err=%b, want 7 0", cycle, seq_err);
        end
        icyc = 1'b1; tick(); idle();
        checks++;
        if ({cycle, seq_err} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL cyc_wrap: got cyc=%0d err=%b, want 0 1", cycle, seq_err);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (seq_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got err=%b, want 1", seq_err);
        end
        apply_reset();
        checks++;
        if (seq_err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got err=%b, want 0", seq_err);
        end
        icyc = 1'b1; rcyc = 1'b1; tick(); idle();
        checks++;
        if ({cycle, sync, seq_err} !== {3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL multi_strobe: got cyc=%0d sync=%b err=%b, want 0 1 1", cycle, sync, seq_err);
        end
    endtask

    task automatic test_rdy_hold();
        sinst = 1'b1; tick(); idle();
        databus = 8'hAD; icyc = 1'b1; tick();
        tick(); tick(); idle();
        checks++;
        if ({inst, cycle} !== {8'hAD, 3'd3}) begin
            errors++;
            $display("FAIL rdy_setup: got inst=%h cyc=%0d, want ad 3", inst, cycle);
        end
        rdy = 1'b0; icyc = 1'b1; databus = 8'h11; tick(); tick(); idle();
        checks++;
        if ({inst, cycle} !== {8'hAD, 3'd3}) begin
            errors++;
            $display("FAIL rdy_hold: got inst=%h cyc=%0d, want ad 3", inst, cycle);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inst, cycle, clr} !== {8'h00, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got inst=%h cyc=%0d clr=%b, want 00 0 1", inst, cycle, clr);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int p;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) apply_reset();
            rdy = ($urandom_range(0, 7) != 0);
            p = $urandom_range(0, 11);
            icyc = (p <= 2); rcyc = (p == 3); scyc = (p == 4);
            if (p == 5) {rcyc, scyc, icyc} = 3'($urandom_range(0, 7));
            sinst = ($urandom_range(0, 5) == 0);
            databus = 8'($urandom);
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 15) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 9) == 0) irqdis = ~irqdis;
            tick();
            checks++;
            if ({inst, cycle, clr, nmi, irq, sync, seq_err} !==
                {m_inst, 3'(m_cycle), m_clr, m_nmi, m_irq(), m_fetch, m_err}) begin
                errors++;
                $display("FAIL random[%0d]: got inst=%h cyc=%0d clr=%b nmi=%b irq=%b sync=%b err=%b, want %h %0d %b %b %b %b %b",
                         n, inst, cycle, clr, nmi, irq, sync, seq_err,
                         m_inst, m_cycle, m_clr, m_nmi, m_irq(), m_fetch, m_err);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_nop_flow();
        test_irq_mask();
        test_nmi();
        test_errors();
        test_rdy_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Drives the instruction decoder's `inst`/`cycle` inputs and its `clr`/`nmi`/`irq` request inputs.
- Consumes the decoder's `icyc`/`rcyc`/`scyc`/`sinst` strobes.
- Holds the instruction register and cycle counter.
- Overlaps opcode fetch with the previous instruction's cycle-0 writeback.
- Latches, prioritises and acknowledges reset, NMI and IRQ requests.

Parameters:
- INT_OP, 8'h00, opcode forced into the instruction register on reset and on interrupt entry.
- SYNC_STAGES, 2, flop stages on `nmi_n`/`irq_n` (minimum 2).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  1 = advance; 0 = freeze IR, cycle, fetch and err state
- databus  in  8  data latch contents; opcode source
- icyc  in  1  decoder: advance one cycle
- rcyc  in  1  decoder: last cycle, next opcode address presented
- scyc  in  1  decoder: skip one cycle
- sinst  in  1  decoder: interrupt/reset request serviced
- irqdis  in  1  status I flag
- nmi_n  in  1  external NMI pin, falling-edge sensitive
- irq_n  in  1  external IRQ pin, level, active-low
- inst  out  8  instruction register to decoder
- cycle  out  3  cycle count to decoder
- clr  out  1  reset request pending
- nmi  out  1  NMI request pending
- irq  out  1  IRQ request, masked by irqdis
- sync  out  1  1 = opcode fetch in progress (fetch_pend)
- seq_err  out  1  sticky protocol error

Behaviour:
Reset (async, rst_n=0):
- inst=INT_OP, cycle=0, clr=1, nmi=0, sync=0, seq_err=0.
- Synchronizers cleared to the inactive state (pins high).
- Reset mid-instruction aborts immediately. Outputs are valid in the first cycle after release, so the decoder sees int/cycle0/clr=1.

Strobe priority, evaluated only when rdy=1:
- Priority is rcyc > scyc > icyc.
- Two or more strobes high in the same cycle sets seq_err; the highest-priority strobe still applies.

Strobe effects (rdy=1):
- rcyc: cycle<=0, sync<=1; inst unchanged, so the decoder performs the old instruction's cycle-0 writeback.
- icyc with sync=1 (IR load edge):
  - sync<=0.
  - If clr|nmi|irq: inst<=INT_OP, cycle stays 0, and databus is discarded (fetched opcode is not executed).
  - Else: inst<=databus, cycle<=1.
- icyc with sync=0: cycle<=cycle+1.
  - cycle=7 wraps to 0 and sets seq_err; inst unchanged.
- scyc: cycle<=cycle+2, mod 8. A wrap past 7 sets seq_err. scyc with sync=1 sets seq_err and is otherwise ignored.
- No strobe: state holds.

Interrupt requests:
- NMI edge detect: a synchronized high-to-low transition on nmi_n sets nmi. A new edge while nmi is already set is absorbed.
- irq output = synchronized (~irq_n) & ~irqdis. It is combinational from the synchronizer and irqdis, and has no latch.
- sinst (rdy=1) acknowledges with the same priority as the decoder:
  - clr=1: clear clr.
  - else nmi=1: clear nmi.
  - else: no state change (IRQ is level).
- An NMI edge arriving in the same cycle as its own acknowledge keeps nmi=1; set wins over clear.
- sinst with clr=nmi=irq=0 sets seq_err.

rdy=0:
- Strobes, sinst and the IR load are ignored; inst, cycle and sync hold.
- Synchronizers and the NMI edge latch keep running.

Latency:
- inst/cycle change on the clock edge that samples the strobe; the decoder sees new values the next cycle.
- Pin-to-request: SYNC_STAGES+1 cycles for nmi; SYNC_STAGES cycles for irq.

Test Plan:
- Reset release with no strobes: inst=8'h00, cycle=0, clr=1, sync=0. Pulse icyc+sinst: clr=0, cycle=1.
- NOP flow: inst=8'hEA, cycle=1. Pulse rcyc: cycle=0, sync=1. Then icyc with databus=8'hA9: inst=8'hA9, cycle=1, sync=0.
- IRQ masking: irq_n=0, irqdis=1, then IR load edge with databus=8'h69: inst=8'h69, irq=0. Repeat with irqdis=0: inst=8'h00, cycle=0, irq=1.
- NMI edge: nmi_n 1->0 held low. After SYNC_STAGES+1 cycles nmi=1; after sinst nmi=0 and stays 0 while nmi_n remains low.
- Error cases:
  - icyc at cycle=7: cycle=0, seq_err=1.
  - icyc+rcyc together: cycle=0, sync=1, seq_err=1.
  - seq_err clears only on rst_n=0.
- rdy=0 holds inst=8'hAD, cycle=3 across an icyc pulse. Asserting rst_n=0 mid-instruction forces inst=8'h00, cycle=0, clr=1 without waiting for clk.
